alu_seq: RTL and testbench

//  Parametrised, clocked successor to the combinational datapath ALU. Adds XOR, NOR, SLTU, an

---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked execute-stage ALU with a valid/ready handshake on both sides.
// MULTU/DIVU iterate one bit per cycle; all other ops retire one cycle after accept.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MULDIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal,
  output logic             complete
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_NOR   = 4'b1100
  } op_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     opa_q, opa_d;      // multiplicand / divisor
  logic [WIDTH-1:0]     opb_q, opb_d;      // dividend shifting out, quotient shifting in
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // {product hi, multiplier/product lo}
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 zero_q, zero_d;
  logic                 overflow_q, overflow_d;
  logic                 dbz_q, dbz_d;
  logic                 illegal_q, illegal_d;

  // Shared adder: ADD uses rt, SUB/SLT/SLTU use ~rt with carry-in 1.
  logic                 is_sub;
  logic [WIDTH-1:0]     b_op;
  logic [WIDTH:0]       add_full;
  logic [WIDTH-1:0]     sum;
  logic                 add_ovf;

  assign is_sub   = (alucontrol == OP_SUB) || (alucontrol == OP_SLT) || (alucontrol == OP_SLTU);
  assign b_op     = is_sub ? ~rt : rt;
  assign add_full = {1'b0, rs} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign sum      = add_full[WIDTH-1:0];
  assign add_ovf  = (rs[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);

  // One shift-add multiply step: add multiplicand into the high half, then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step; the top bit of div_diff is the borrow.
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_ok;
  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quo_next;

  assign div_shift = {rem_q[WIDTH-1:0], opb_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, opa_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign rem_next  = div_ok ? div_diff[WIDTH:0] : div_shift;
  assign quo_next  = {opb_q[WIDTH-2:0], div_ok};

  logic                 load_out;
  logic [WIDTH-1:0]     res_v, hi_v;
  logic                 ovf_v, dbz_v, ill_v;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    illegal_d   = illegal_q;
    load_out    = 1'b0;
    res_v       = '0;
    hi_v        = '0;
    ovf_v       = 1'b0;
    dbz_v       = 1'b0;
    ill_v       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_out = 1'b1;
          case (op_e'(alucontrol))
            OP_AND:  res_v = rs & rt;
            OP_OR:   res_v = rs | rt;
            OP_XOR:  res_v = rs ^ rt;
            OP_NOR:  res_v = ~(rs | rt);
            OP_ADD, OP_SUB: begin
              res_v = sum;
              ovf_v = add_ovf;
            end
            OP_SLT:  res_v = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_SLTU: res_v = {{(WIDTH-1){1'b0}}, ~add_full[WIDTH]};
            OP_MULTU: begin
              if (MULDIV != 0) begin
                load_out = 1'b0;
                opa_d    = rs;
                acc_d    = {{WIDTH{1'b0}}, rt};
                cnt_d    = '0;
                state_d  = S_MUL;
              end else begin
                ill_v = 1'b1;
              end
            end
            OP_DIVU: begin
              if (MULDIV == 0) begin
                ill_v = 1'b1;
              end else if (rt == '0) begin
                res_v = '1;
                hi_v  = rs;
                dbz_v = 1'b1;
              end else begin
                load_out = 1'b0;
                opa_d    = rt;
                opb_d    = rs;
                rem_d    = '0;
                cnt_d    = '0;
                state_d  = S_DIV;
              end
            end
            default: ill_v = 1'b1;
          endcase
        end
      end

      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          load_out = 1'b1;
          res_v    = mul_next[WIDTH-1:0];
          hi_v     = mul_next[2*WIDTH-1:WIDTH];
        end
      end

      S_DIV: begin
        rem_d = rem_next;
        opb_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          load_out = 1'b1;
          res_v    = quo_next;
          hi_v     = rem_next[WIDTH-1:0];
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (load_out) begin
      state_d     = S_DONE;
      result_d    = res_v;
      result_hi_d = hi_v;
      zero_d      = (res_v == '0);
      overflow_d  = ovf_v;
      dbz_d       = dbz_v;
      illegal_d   = ill_v;
    end
  end

  // NOTE: datapath registers are reset too, because an aborted op must leave every output at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign complete    = out_valid;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops checked against a
// plain-arithmetic reference model; a second instance has MULTU/DIVU disabled.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alucontrol;
  logic [31:0] rs, rt, result, result_hi;
  logic        zero, overflow, div_by_zero, illegal, complete;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0]  n_alucontrol;
  logic [31:0] n_rs, n_rt, n_result, n_result_hi;
  logic        n_zero, n_overflow, n_div_by_zero, n_illegal, n_complete;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MULDIV(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .alucontrol(alucontrol),
    .rs(rs), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero), .illegal(illegal), .complete(complete)
  );

  alu_seq #(.WIDTH(32), .MULDIV(0)) dut_nomd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .alucontrol(n_alucontrol),
    .rs(n_rs), .rt(n_rt),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .result_hi(n_result_hi), .zero(n_zero), .overflow(n_overflow),
    .div_by_zero(n_div_by_zero), .illegal(n_illegal), .complete(n_complete)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        dbz;
    logic        ill;
  } exp_t;

  // Reference model: results straight from the opcode table using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    e = '{lo: 32'h0, hi: 32'h0, z: 1'b0, ov: 1'b0, dbz: 1'b0, ill: 1'b0};
    case (op)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0011: e.lo = a ^ b;
      4'b1100: e.lo = ~(a | b);
      4'b0010: begin
        e.lo = a + b;
        s    = longint'($signed(a)) + longint'($signed(b));
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        e.lo = a - b;
        s    = longint'($signed(a)) - longint'($signed(b));
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.lo = (a < b) ? 32'd1 : 32'd0;
      4'b1001: begin
        p    = {32'h0, a} * {32'h0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      4'b1010: begin
        if (b == 32'h0) begin
          e.lo  = 32'hFFFF_FFFF;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.lo == 32'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, " result"},      64'(result),      64'(e.lo));
    check({tag, " result_hi"},   64'(result_hi),   64'(e.hi));
    check({tag, " zero"},        64'(zero),        64'(e.z));
    check({tag, " overflow"},    64'(overflow),    64'(e.ov));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
    check({tag, " illegal"},     64'(illegal),     64'(e.ill));
    check({tag, " complete"},    64'(complete),    64'(out_valid));
  endtask

  // Issue one op on the main DUT, check latency and fields, optionally stall, then retire.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t e;
    int   lat;
    int   exp_lat;
    e       = model(op, a, b);
    exp_lat = (op == 4'b1001 || (op == 4'b1010 && b != 32'h0)) ? 33 : 1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    alucontrol = op;
    rs         = a;
    rt         = b;
    @(negedge clk);
    in_valid   = 1'b0;
    alucontrol = 4'($urandom);
    rs         = $urandom;
    rt         = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_out(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rs = $urandom;
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold in_ready"},  64'(in_ready),  64'd0);
      check_out({tag, " hold"}, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " retired"}, 64'(out_valid), 64'd0);
  endtask

  // Issue one op on the MULDIV=0 instance; every op there takes one cycle.
  task automatic run_nomd(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic exp_ill, input logic [31:0] exp_lo);
    n_in_valid   = 1'b1;
    n_alucontrol = op;
    n_rs         = a;
    n_rt         = b;
    @(negedge clk);
    n_in_valid   = 1'b0;
    check({tag, " out_valid"}, 64'(n_out_valid), 64'd1);
    check({tag, " illegal"},   64'(n_illegal),   64'(exp_ill));
    check({tag, " result"},    64'(n_result),    64'(exp_lo));
    check({tag, " result_hi"}, 64'(n_result_hi), 64'd0);
    check({tag, " zero"},      64'(n_zero),      64'(exp_lo == 32'h0));
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    alucontrol   = 4'h0;
    rs           = 32'h0;
    rt           = 32'h0;
    n_in_valid   = 1'b0;
    n_out_ready  = 1'b0;
    n_alucontrol = 4'h0;
    n_rs         = 32'h0;
    n_rt         = 32'h0;

    @(negedge clk);
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result",    64'(result),    64'd0);
    check("reset zero",      64'(zero),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_zero", 4'b0110, 32'd5,         32'd5,         0);
    run_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1,         0);
    run_op("sltu",     4'b1000, 32'hFFFF_FFFF, 32'd1,         0);
    run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1,         0);
    run_op("multu",    4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu",     4'b1010, 32'd100,       32'd7,         0);
    run_op("hold",     4'b0011, 32'hA5A5_0F0F, 32'h0FF0_1234, 5);
    run_op("b2b_nor",  4'b1100, 32'h1234_5678, 32'h0000_FFFF, 0);
    run_op("illegal",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("div0",     4'b1010, 32'd9,         32'd0,         0);

    // Abort a multiply with reset partway through; stale DIVU-by-0 outputs must clear too.
    in_valid   = 1'b1;
    alucontrol = 4'b1001;
    rs         = 32'hDEAD_BEEF;
    rt         = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-abort in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort in_ready",    64'(in_ready),    64'd1);
    check("abort out_valid",   64'(out_valid),   64'd0);
    check("abort result",      64'(result),      64'd0);
    check("abort result_hi",   64'(result_hi),   64'd0);
    check("abort div_by_zero", 64'(div_by_zero), 64'd0);
    check("abort flags",       64'({zero, overflow, illegal, complete}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("add_after_rst", 4'b0010, 32'h0000_1000, 32'h0000_0234, 0);

    run_nomd("nomd_multu", 4'b1001, 32'd3, 32'd4, 1'b1, 32'h0);
    run_nomd("nomd_divu",  4'b1010, 32'd8, 32'd2, 1'b1, 32'h0);
    run_nomd("nomd_add",   4'b0010, 32'd3, 32'd4, 1'b0, 32'd7);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d op%b", i, op), op, a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
